// File: rtl/ifmap_row_sender_if.sv
// Bundle of the control, upstream and ifmap-buffer signals of the row sender.
// The sender drives through the master modport; the environment uses slave.
interface ifmap_row_sender_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int OUT_WIDTH  = DATA_WIDTH + 2
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  row_len;
  logic [LEN_WIDTH-1:0]  flush_len;
  logic                  flush_en;
  logic [DATA_WIDTH-1:0] src_data;
  logic                  src_valid;
  logic                  src_ready;
  logic [OUT_WIDTH-1:0]  buf_in;
  logic                  buf_wen;
  logic                  buf_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, row_len, flush_len, flush_en, src_data, src_valid, buf_ready,
    output src_ready, buf_in, buf_wen, busy, done
  );

  modport slave (
    output start, row_len, flush_len, flush_en, src_data, src_valid, buf_ready,
    input  src_ready, buf_in, buf_wen, busy, done
  );
endinterface

// File: rtl/ifmap_row_sender.sv
// Streams one ifmap row (plus an optional zero flush row) into the ifmap buffer,
// tagging first/last words of each sub-row through a single registered output stage.
module ifmap_row_sender #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 5,
  parameter int OUT_WIDTH  = DATA_WIDTH + 2
) (
  input logic               clk,
  input logic               reset_n,
  ifmap_row_sender_if.master bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROW   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]            state_reg, state_next;
  logic [LEN_WIDTH-1:0]  row_len_reg, flush_len_reg;
  logic                  flush_en_reg;
  logic [LEN_WIDTH-1:0]  load_cnt_reg, beat_cnt_reg;
  logic [OUT_WIDTH-1:0]  buf_in_reg;
  logic                  buf_wen_reg;

  logic                  in_sub_row;
  logic [LEN_WIDTH-1:0]  cur_len, last_idx;
  logic                  beat, stage_free, can_load, load, sub_last, flush_after_row;
  logic [DATA_WIDTH-1:0] load_data;
  logic [1:0]            load_tag;

  // Row and flush share the counters and the output stage; only the length differs.
  always_comb begin
    in_sub_row      = (state_reg == ROW) || (state_reg == FLUSH);
    cur_len         = (state_reg == FLUSH) ? flush_len_reg : row_len_reg;
    last_idx        = cur_len - LEN_ONE;
    beat            = buf_wen_reg && bus.buf_ready;
    stage_free      = !buf_wen_reg || bus.buf_ready;
    can_load        = in_sub_row && (load_cnt_reg < cur_len) && stage_free;
    load            = (state_reg == ROW) ? (can_load && bus.src_valid) : can_load;
    load_data       = (state_reg == ROW) ? bus.src_data : '0;
    load_tag        = {load_cnt_reg == '0, load_cnt_reg == last_idx};
    sub_last        = beat && (beat_cnt_reg == last_idx);
    flush_after_row = flush_en_reg && (flush_len_reg != '0);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (bus.row_len != '0)
            state_next = ROW;
          else if (bus.flush_en && (bus.flush_len != '0))
            state_next = FLUSH;
          else
            state_next = FIN;
        end
      end
      ROW:     if (sub_last) state_next = flush_after_row ? FLUSH : FIN;
      FLUSH:   if (sub_last) state_next = FIN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      row_len_reg   <= '0;
      flush_len_reg <= '0;
      flush_en_reg  <= 1'b0;
      load_cnt_reg  <= '0;
      beat_cnt_reg  <= '0;
      buf_in_reg    <= '0;
      buf_wen_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && bus.start) begin
        row_len_reg   <= bus.row_len;
        flush_len_reg <= bus.flush_len;
        flush_en_reg  <= bus.flush_en;
      end
      if (state_next != state_reg) begin
        load_cnt_reg <= '0;
        beat_cnt_reg <= '0;
      end else begin
        if (load) load_cnt_reg <= load_cnt_reg + LEN_ONE;
        if (beat) beat_cnt_reg <= beat_cnt_reg + LEN_ONE;
      end
      // A load in the same cycle as a beat replaces the word; otherwise a beat empties the stage.
      if (load) begin
        buf_in_reg  <= {load_tag, load_data};
        buf_wen_reg <= 1'b1;
      end else if (beat) begin
        buf_wen_reg <= 1'b0;
      end
    end
  end

  assign bus.src_ready = (state_reg == ROW) && can_load;
  assign bus.buf_in    = buf_in_reg;
  assign bus.buf_wen   = buf_wen_reg;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == FIN);
endmodule

// File: tb/tb_ifmap_row_sender.sv
// Scenario bench for ifmap_row_sender: random source data and buffer stalls,
// beats compared against a queue-based model of the tagged output stream.
module tb_ifmap_row_sender;
  localparam int DW = 16;
  localparam int LW = 5;
  localparam int OW = 18;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ifmap_row_sender_if #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUT_WIDTH(OW)) bus();

  ifmap_row_sender #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .OUT_WIDTH(OW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int done_cnt = 0;
  int stall_err = 0;
  int ready_mode = 0;
  bit rand_valid = 1'b0;
  bit hold_pending = 1'b0;
  logic [OW-1:0] hold_val;
  logic [OW-1:0] got_q[$];
  logic [OW-1:0] exp_q[$];
  int got_cyc[$];
  logic [DW-1:0] src_q[$];

  // Observer: records beats and done pulses, and flags any change of a stalled word.
  always @(negedge clk) begin
    cycle++;
    if (!reset_n) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && !(bus.buf_wen && bus.buf_in === hold_val)) stall_err++;
      if (bus.buf_wen && bus.buf_ready) begin
        got_q.push_back(bus.buf_in);
        got_cyc.push_back(cycle);
      end
      if (bus.done) done_cnt++;
      hold_pending = bus.buf_wen && !bus.buf_ready;
      hold_val = bus.buf_in;
    end
  end

  task automatic drive_cycle();
    bit acc;
    @(negedge clk);
    acc = bus.src_valid && bus.src_ready;
    @(posedge clk);
    #1;
    if (acc && src_q.size() > 0) void'(src_q.pop_front());
    bus.start = 1'b0;
    case (ready_mode)
      0:       bus.buf_ready = 1'b1;
      1:       bus.buf_ready = !bus.buf_ready;
      default: bus.buf_ready = 1'($urandom_range(0, 1));
    endcase
    if (src_q.size() > 0) begin
      bus.src_data  = src_q[0];
      bus.src_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end else begin
      bus.src_data  = DW'($urandom);
      bus.src_valid = 1'b0;
    end
  endtask

  // Expected stream: each sub-row tagged first=10, last=01, single=11, flush data zero.
  task automatic begin_row(input int rl, input int fl, input bit fe);
    exp_q.delete();
    for (int i = 0; i < rl; i++) exp_q.push_back({i == 0, i == rl - 1, src_q[i]});
    if (fe) for (int i = 0; i < fl; i++) exp_q.push_back({i == 0, i == fl - 1, DW'(0)});
    got_q.delete();
    got_cyc.delete();
    done_cnt = 0;
    stall_err = 0;
    bus.start     = 1'b1;
    bus.row_len   = LW'(rl);
    bus.flush_len = LW'(fl);
    bus.flush_en  = fe;
    if (src_q.size() > 0) begin
      bus.src_data  = src_q[0];
      bus.src_valid = 1'b1;
    end
  endtask

  task automatic wait_done(output bit timed_out);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin
      drive_cycle();
      n++;
    end
    repeat (3) drive_cycle();
    timed_out = (done_cnt == 0);
  endtask

  task automatic fill_src(input int n);
    src_q.delete();
    for (int i = 0; i < n; i++) src_q.push_back(DW'($urandom));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.buf_wen !== 1'b0) begin errors++; $display("FAIL reset_buf_wen got %b want 0", bus.buf_wen); end
    checks++; if (bus.buf_in !== '0) begin errors++; $display("FAIL reset_buf_in got %h want 0", bus.buf_in); end
    checks++; if (bus.src_ready !== 1'b0) begin errors++; $display("FAIL reset_src_ready got %b want 0", bus.src_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    $display("test_reset: outputs idle under reset");
  endtask

  task automatic test_basic();
    logic [OW-1:0] want[3];
    bit to;
    want[0] = 18'h20005; want[1] = 18'h00006; want[2] = 18'h10007;
    ready_mode = 0; rand_valid = 1'b0;
    src_q.delete(); src_q.push_back(16'd5); src_q.push_back(16'd6); src_q.push_back(16'd7);
    begin_row(3, 0, 1'b0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++; if (got_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== want[i]) begin errors++; $display("FAIL basic_beat%0d got %h want %h", i, got_q[i], want[i]); end
    end
    if (got_cyc.size() == 3) begin
      checks++; if (got_cyc[2] - got_cyc[0] != 2) begin errors++; $display("FAIL basic_consecutive got span %0d want 2", got_cyc[2] - got_cyc[0]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    $display("test_basic: %0d beats, %0d done", got_q.size(), done_cnt);
  endtask

  task automatic test_flush();
    bit to;
    ready_mode = 0; rand_valid = 1'b0;
    fill_src(12);
    begin_row(12, 5, 1'b1);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL flush_timeout got no done want done"); end
    checks++; if (got_q.size() != 17) begin errors++; $display("FAIL flush_count got %0d want 17", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL flush_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL flush_done got %0d want 1", done_cnt); end
    $display("test_flush: %0d beats, %0d done", got_q.size(), done_cnt);
  endtask

  task automatic test_single();
    bit to;
    ready_mode = 0; rand_valid = 1'b0;
    src_q.delete(); src_q.push_back(16'h00FF);
    begin_row(1, 1, 1'b1);
    wait_done(to);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL single_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== 18'h300FF) begin errors++; $display("FAIL single_row got %h want 300ff", got_q[0]); end
      checks++; if (got_q[1] !== 18'h30000) begin errors++; $display("FAIL single_flush got %h want 30000", got_q[1]); end
    end
    $display("test_single: %0d beats", got_q.size());
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] words[$];
    logic [OW-1:0] ref_q[$];
    bit to;
    fill_src(8);
    words = src_q;
    ready_mode = 0; rand_valid = 1'b0;
    begin_row(8, 0, 1'b0);
    wait_done(to);
    ref_q = got_q;
    src_q = words;
    ready_mode = 1; rand_valid = 1'b1;
    bus.buf_ready = 1'b1;
    begin_row(8, 0, 1'b0);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL stall_timeout got no done want done"); end
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL stall_count got %0d want 8", got_q.size()); end
    for (int i = 0; i < 8 && i < got_q.size() && i < ref_q.size(); i++) begin
      checks++; if (got_q[i] !== ref_q[i] || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL stall_beat%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++; if (stall_err != 0) begin errors++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
    $display("test_back_to_back: %0d beats under stalls", got_q.size());
    ready_mode = 0; rand_valid = 1'b0;
  endtask

  task automatic test_empty();
    int lens[3][3];
    bit to;
    lens[0] = '{0, 0, 0}; lens[1] = '{0, 3, 1}; lens[2] = '{4, 0, 1};
    ready_mode = 0; rand_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_src(lens[k][0]);
      begin_row(lens[k][0], lens[k][1], lens[k][2] != 0);
      wait_done(to);
      checks++; if (got_q.size() != exp_q.size() || done_cnt != 1) begin
        errors++; $display("FAIL empty%0d_count got %0d beats %0d done want %0d beats 1 done", k, got_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL empty%0d_beat%0d got %h want %h", k, i, got_q[i], exp_q[i]); end
      end
      $display("test_empty: row %0d flush %0d en %0d -> %0d beats", lens[k][0], lens[k][1], lens[k][2], got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    bit to;
    ready_mode = 0; rand_valid = 1'b0;
    fill_src(6);
    begin_row(6, 0, 1'b0);
    while (got_q.size() < 2 && n < 100) begin drive_cycle(); n++; end
    checks++; if (got_q.size() < 2) begin errors++; $display("FAIL midreset_progress got %0d beats want 2", got_q.size()); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.buf_wen !== 1'b0) begin errors++; $display("FAIL midreset_buf_wen got %b want 0", bus.buf_wen); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.src_valid = 1'b0;
    fill_src(2);
    begin_row(2, 0, 1'b0);
    wait_done(to);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL midreset_count got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      checks++; if (got_q[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_first got %h want %h", got_q[0], exp_q[0]); end
      checks++; if (got_q[1][OW-1:OW-2] !== 2'b01) begin errors++; $display("FAIL midreset_last_tag got %b want 01", got_q[1][OW-1:OW-2]); end
    end
    $display("test_reset_mid: restarted row gave %0d beats", got_q.size());
  endtask

  task automatic test_start_busy();
    bit to;
    ready_mode = 0; rand_valid = 1'b1;
    fill_src(10);
    begin_row(10, 0, 1'b0);
    repeat (4) drive_cycle();
    bus.start = 1'b1; bus.row_len = 5'd3;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_flag got %b want 1", bus.busy); end
    wait_done(to);
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL busy_count got %0d want 10", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_beat%0d got %h want %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done got %0d want 1", done_cnt); end
    $display("test_start_busy: %0d beats, %0d done", got_q.size(), done_cnt);
    rand_valid = 1'b0;
  endtask

  task automatic test_random();
    int rl, fl;
    bit fe, to;
    ready_mode = 2; rand_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rl = $urandom_range(0, 12);
      fl = $urandom_range(0, 6);
      fe = 1'($urandom_range(0, 1));
      fill_src(rl);
      begin_row(rl, fl, fe);
      wait_done(to);
      checks++; if (to || got_q.size() != exp_q.size() || done_cnt != 1) begin
        errors++; $display("FAIL rand%0d_count got %0d beats %0d done want %0d beats 1 done", k, got_q.size(), done_cnt, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_beat%0d got %h want %h", k, i, got_q[i], exp_q[i]); end
      end
      checks++; if (stall_err != 0) begin errors++; $display("FAIL rand%0d_hold got %0d changes want 0", k, stall_err); end
      $display("test_random: row %0d flush %0d en %0d -> %0d beats", rl, fl, fe, got_q.size());
    end
    ready_mode = 0; rand_valid = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.row_len = '0; bus.flush_len = '0; bus.flush_en = 1'b0;
    bus.src_data = '0; bus.src_valid = 1'b0; bus.buf_ready = 1'b1;
    #3;
    test_reset();
    test_basic();
    test_flush();
    test_single();
    test_back_to_back();
    test_empty();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog expired");
  end
endmodule
